// File: rtl/agu_arbiter.sv
// Shared LC-3b address-generation unit: two requesters are served round-robin
// through one sext/shift/add path into a registered, back-pressurable output.
module agu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_inst,
  input  logic [15:0] req0_base,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_inst,
  input  logic [15:0] req1_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic        out_tag,
  output logic        out_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        tag_q, tag_d;
  logic        err_q, err_d;
  logic        last_q, last_d;

  logic        can_accept;
  logic        grant0, grant1;
  logic        accept;
  logic [15:0] sel_inst, sel_base;
  logic [15:0] offset;
  logic        illegal;

  // last_q names the most recent winner; on contention the other one wins.
  always_comb begin
    can_accept = (state_q == EMPTY) | out_ready;
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
  end

  assign req0_ready = grant0 & can_accept & ~reset;
  assign req1_ready = grant1 & can_accept & ~reset;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_inst = grant1 ? req1_inst : req0_inst;
    sel_base = grant1 ? req1_base : req0_base;
  end

  // Offsets are sign-extended first, then shifted; the top bit falls off.
  always_comb begin
    offset  = '0;
    illegal = 1'b0;
    case (sel_inst[15:12])
      4'b0000, 4'b1110: offset = {{6{sel_inst[8]}}, sel_inst[8:0], 1'b0};
      4'b0100: if (sel_inst[11]) offset = {{4{sel_inst[10]}}, sel_inst[10:0], 1'b0};
      4'b0010, 4'b0011: offset = {{10{sel_inst[5]}}, sel_inst[5:0]};
      4'b0110, 4'b0111: offset = {{9{sel_inst[5]}}, sel_inst[5:0], 1'b0};
      4'b1100: offset = '0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    err_d   = err_q;
    last_d  = last_q;
    if (accept) begin
      state_d = FULL;
      addr_d  = sel_base + offset;
      tag_d   = grant1;
      err_d   = illegal;
      last_d  = grant1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      tag_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_addr  = addr_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_agu_arbiter.sv
// Directed self-checking bench for agu_arbiter with hand-computed expectations.
module tb_agu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_inst, req0_base, req1_inst, req1_base;
  logic        out_valid, out_ready, out_tag, out_err;
  logic [15:0] out_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  agu_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_inst (req0_inst),
    .req0_base (req0_base),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_inst (req1_inst),
    .req1_base (req1_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] a,
                           input logic t, input logic e);
    check({tag, ".valid"}, 16'(out_valid), 16'(v));
    check({tag, ".addr"},  out_addr,       a);
    check({tag, ".tag"},   16'(out_tag),   16'(t));
    check({tag, ".err"},   16'(out_err),   16'(e));
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    check({tag, ".r0"}, 16'(req0_ready), 16'(r0));
    check({tag, ".r1"}, 16'(req1_ready), 16'(r1));
  endtask

  logic [15:0] v_inst [3] = '{16'h4BFF, 16'hD000, 16'h4000};
  logic [15:0] v_base [3] = '{16'hFC00, 16'h1234, 16'h5555};
  logic [15:0] v_addr [3] = '{16'h03FE, 16'h1234, 16'h5555};
  logic        v_err  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_inst  = 16'h01FF;
    req0_base  = 16'h3000;
    req1_inst  = '0;
    req1_base  = '0;
    out_ready  = 1'b1;
    #2;
    check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    check_ready("reset", 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Single BR from requester 0
    #1;
    check_ready("br", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_out("br", 1'b1, 16'h2FFE, 1'b0, 1'b0);
    tick();
    check("br.drain", 16'(out_valid), 16'd0);

    // Byte vs word offset from requester 1, back to back
    req1_valid = 1'b1;
    req1_inst  = 16'h2020;
    req1_base  = 16'h1000;
    #1;
    check_ready("ldb", 1'b0, 1'b1);
    tick();
    check_out("ldb", 1'b1, 16'h0FE0, 1'b1, 1'b0);
    req1_inst = 16'h6020;
    #1;
    check_ready("ldw", 1'b0, 1'b1);
    tick();
    check_out("ldw", 1'b1, 16'h0FC0, 1'b1, 1'b0);
    req1_valid = 1'b0;
    tick();
    check("ldw.drain", 16'(out_valid), 16'd0);

    // Fairness: both valid, last winner was requester 1 so 0 goes first
    req0_valid = 1'b1; req0_inst = 16'hC000; req0_base = 16'h1111;
    req1_valid = 1'b1; req1_inst = 16'hC000; req1_base = 16'h2222;
    for (int unsigned i = 0; i < 6; i++) begin
      #1;
      check_ready("rr", (i % 2) == 0, (i % 2) == 1);
      tick();
      check_out("rr", 1'b1, ((i % 2) == 0) ? 16'h1111 : 16'h2222, (i % 2) == 1, 1'b0);
    end

    // Backpressure: hold requester 1's result for three cycles
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check_ready("hold", 1'b0, 1'b0);
      tick();
      check_out("hold", 1'b1, 16'h2222, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_ready("release", 1'b1, 1'b0);
    tick();
    check_out("release", 1'b1, 16'h1111, 1'b0, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("release.drain", 16'(out_valid), 16'd0);

    // Wrap, illegal opcode, JSRR at full throughput
    req0_valid = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      req0_inst = v_inst[i];
      req0_base = v_base[i];
      #1;
      check_ready("addr", 1'b1, 1'b0);
      tick();
      check_out("addr", 1'b1, v_addr[i], 1'b0, v_err[i]);
    end
    req0_valid = 1'b0;
    tick();

    // Async reset while a result is held; reset must restore last=1
    req0_valid = 1'b1;
    req0_inst  = 16'h01FF;
    req0_base  = 16'h3000;
    out_ready  = 1'b0;
    tick();
    req0_valid = 1'b0;
    check_out("pre_rst", 1'b1, 16'h2FFE, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    req0_valid = 1'b1; req0_inst = 16'hC000; req0_base = 16'h1111;
    req1_valid = 1'b1; req1_inst = 16'hC000; req1_base = 16'h2222;
    out_ready  = 1'b1;
    #1;
    check_ready("in_rst", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check_ready("post_rst", 1'b1, 1'b0);
    tick();
    check_out("post_rst", 1'b1, 16'h1111, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/agu_arbiter.md
# agu_arbiter

Shared address-generation unit for the LC-3b datapath: one sign-extend/shift/add path that two requesters time-share. Requester 0 is the fetch/branch unit and requester 1 is the memory unit. For each accepted request the block decodes the instruction's offset field, sign-extends it to 16 bits, optionally shifts it left by 1, and adds it to the supplied base. Requesters are served round-robin through valid/ready handshakes, and the block has a registered, back-pressurable output.

## Interface
- No parameters. The data width is fixed at 16 bits and there are exactly 2 requesters.
- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0's request is accepted this cycle.
- req0_inst  in  16  requester 0's instruction word.
- req0_base  in  16  requester 0's base value (PC or BaseR contents).
- req1_valid / req1_ready / req1_inst / req1_base  same as above, for requester 1.
- out_valid  out  1  the output register holds a result.
- out_ready  in  1  the consumer accepts the result.
- out_addr  out  16  computed address.
- out_tag  out  1  index of the requester that produced the result.
- out_err  out  1  the opcode had no address form; out_addr = base.

## Operation
Offset decode uses opcode = inst[15:12]:
- 0000 BR, 1110 LEA: sext(inst[8:0]) << 1.
- 0100 JSR with inst[11]=1: sext(inst[10:0]) << 1. With inst[11]=0 (JSRR): offset 0.
- 0010 LDB, 0011 STB: sext(inst[5:0]), no shift.
- 0110 LDW, 0111 STW: sext(inst[5:0]) << 1.
- 1100 JMP/RET: offset 0.
- Any other opcode: offset 0 and out_err=1.

Arithmetic:
- addr = (base + offset) mod 2^16.
- The 16-bit add wraps and no carry is reported.
- The shift is applied after sign extension, and the shift result is truncated to 16 bits.

Output register behaves as a two-state machine:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
- An accept loads the register: EMPTY→FULL, or FULL→FULL if a drain happens in the same cycle.
- A drain (out_valid & out_ready) with no accept: FULL→EMPTY.

Arbitration:
- can_accept = !out_valid | out_ready.
- Round-robin pointer `last` holds the index of the most recently granted requester; reset value is 1, so requester 0 wins first.
- If both requesters are valid, the one that is not `last` is granted. If only one is valid, that one is granted.
- reqN_ready = grantN & can_accept. This is combinational from the valids, out_ready and the state; it is never asserted for a requester whose valid is low.
- At most one ready is high per cycle.
- `last` updates only on an accepted transfer.

Holding rules:
- While FULL and out_ready=0, out_addr, out_tag and out_err hold stable and both readys are 0.
- Requesters must hold inst and base stable while valid is high and ready is low.

## Timing
- Latency: a request accepted at edge N produces out_valid=1 with its result after edge N. The result is visible in cycle N+1.
- Throughput is one result per cycle while out_ready=1.
- Simultaneous drain and accept in the same cycle: the register is reloaded and out_valid stays 1, with no bubble.
- Reset values (asserted asynchronously, effective immediately):
  - out_valid=0, out_addr=0x0000, out_tag=0, out_err=0, last=1.
  - reqN_ready=0 while reset is high.
- Reset asserted mid-operation discards the held result, and no transfer completes in that cycle.
- After reset deasserts, the first grant goes to requester 0 if it is valid.
- Datapath depth is one sign-extend mux plus a 16-bit adder between the request inputs and the output register.

## Test plan
- Single BR: req0 inst=0x01FF, base=0x3000, out_ready=1. Expect req0_ready=1, then next cycle out_addr=0x2FFE, out_tag=0, out_err=0.
- Byte vs word offset: req1 sends LDB 0x2020 with base 0x1000, then LDW 0x6020 with base 0x1000. Expect 0x0FE0, then 0x0FC0, with out_tag=1 for both.
- Fairness: after reset both requesters are valid continuously and out_ready=1. Expect grants 0,1,0,1,… and out_tag alternating with no idle cycles.
- Backpressure: result held with out_ready=0 for 3 cycles. Expect out_addr and out_tag unchanged and both readys 0. Then out_ready=1: the drain and the next accept happen in the same cycle, and out_valid stays 1.
- Wrap and illegal opcode:
  - JSR 0x4BFF with base 0xFC00 → out_addr=0x03FE.
  - Opcode 0xD000 with base 0x1234 → out_addr=0x1234, out_err=1.
  - JSRR 0x4000 with base 0x5555 → out_addr=0x5555, out_err=0.
- Async reset mid-operation: assert reset between clock edges while out_valid=1. Expect out_valid=0 immediately. After release, with both requesters valid, the first grant goes to requester 0.
